// File: rtl/hist_pkg.sv
// Shared definitions for the histogram bin accumulator.
// Default geometry, FSM encoding and the zero-interval bin.
package hist_pkg;

    localparam int HIST_ADDR_W  = 8;
    localparam int HIST_COUNT_W = 16;

    // Bin the distributer uses for a zero time interval
    localparam int BIN_ZERO = 128;

    typedef enum logic [2:0] {
        ST_CLEAR     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_INC_RD    = 3'd2,
        ST_INC_DATA  = 3'd3,
        ST_INC_WR    = 3'd4,
        ST_HOST_RD   = 3'd5,
        ST_HOST_DATA = 3'd6
    } hist_state_e;

endpackage

// File: rtl/hist_bin_ram.sv
// Single-port bin-count RAM, one-cycle registered read.
// Contents are not reset; the owner sweeps it to zero.
module hist_bin_ram #(
    parameter int ADDR_W  = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [COUNT_W-1:0] wdata,
    output logic [COUNT_W-1:0] rdata
);

    logic [COUNT_W-1:0] mem_q [2**ADDR_W];
    logic [COUNT_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/histogram_accumulator.sv
// Time-correlation histogram: edge-triggered bin increments via
// read-modify-write, host readout port and a full clear sweep.
module histogram_accumulator
    import hist_pkg::*;
#(
    parameter int ADDR_W  = HIST_ADDR_W,
    parameter int COUNT_W = HIST_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  Addr,
    input  logic               Memory_add,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_ready,
    output logic               rd_valid,
    output logic [COUNT_W-1:0] rd_data,
    input  logic               clear_req,
    output logic               busy,
    output logic               saturated,
    output logic               dropped
);

    localparam logic [ADDR_W-1:0]  PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    hist_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic               pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0]  op_addr_q, op_addr_d;
    logic [COUNT_W-1:0] data_q, data_d;
    logic [COUNT_W-1:0] rd_data_q, rd_data_d;
    logic               sat_q, sat_d;
    logic               drop_q, drop_d;
    logic               mem_add_q;

    logic               ram_en;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [COUNT_W-1:0] ram_wdata;
    logic [COUNT_W-1:0] ram_rdata;

    logic req_edge;
    logic rd_accept;
    logic pend_busy;

    assign req_edge  = Memory_add & ~mem_add_q;
    assign rd_ready  = (state_q == ST_IDLE) & ~pend_valid_q;
    assign rd_accept = rd_req & rd_ready;
    // The entry frees up in the same cycle its read is issued
    assign pend_busy = pend_valid_q & (state_q != ST_INC_RD);

    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        op_addr_d    = op_addr_q;
        data_d       = data_q;
        rd_data_d    = rd_data_q;
        sat_d        = sat_q;
        drop_d       = drop_q;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = op_addr_q;
        ram_wdata    = '0;

        unique case (state_q)
            ST_CLEAR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_ptr_q;
                clr_ptr_d = clr_ptr_q + PTR_ONE;
                if (clr_ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // A same-cycle edge loses to the host read and waits
                if (pend_valid_q) begin
                    state_d = ST_INC_RD;
                end else if (rd_accept) begin
                    state_d   = ST_HOST_RD;
                    op_addr_d = rd_addr;
                end else if (req_edge) begin
                    state_d = ST_INC_RD;
                end
            end
            ST_INC_RD: begin
                ram_en       = 1'b1;
                ram_addr     = pend_addr_q;
                op_addr_d    = pend_addr_q;
                pend_valid_d = 1'b0;
                state_d      = ST_INC_DATA;
            end
            ST_INC_DATA: begin
                data_d  = ram_rdata;
                state_d = ST_INC_WR;
            end
            ST_INC_WR: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = op_addr_q;
                if (data_q == '1) begin
                    ram_wdata = data_q;
                    sat_d     = 1'b1;
                end else begin
                    ram_wdata = data_q + CNT_ONE;
                end
                state_d = ST_IDLE;
            end
            ST_HOST_RD: begin
                ram_en   = 1'b1;
                ram_addr = op_addr_q;
                state_d  = ST_HOST_DATA;
            end
            ST_HOST_DATA: begin
                rd_data_d = ram_rdata;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        if (req_edge && (state_q != ST_CLEAR)) begin
            if (pend_busy) begin
                drop_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_addr_d  = Addr;
            end
        end

        // Clear wins over everything, including a coincident edge
        if (clear_req) begin
            state_d      = ST_CLEAR;
            clr_ptr_d    = '0;
            pend_valid_d = 1'b0;
            sat_d        = 1'b0;
            drop_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            op_addr_q    <= '0;
            data_q       <= '0;
            rd_data_q    <= '0;
            sat_q        <= 1'b0;
            drop_q       <= 1'b0;
            mem_add_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            op_addr_q    <= op_addr_d;
            data_q       <= data_d;
            rd_data_q    <= rd_data_d;
            sat_q        <= sat_d;
            drop_q       <= drop_d;
            mem_add_q    <= Memory_add;
        end
    end

    hist_bin_ram #(
        .ADDR_W  (ADDR_W),
        .COUNT_W (COUNT_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign rd_valid  = (state_q == ST_HOST_DATA);
    assign rd_data   = rd_valid ? ram_rdata : rd_data_q;
    assign busy      = (state_q == ST_CLEAR);
    assign saturated = sat_q;
    assign dropped   = drop_q;

endmodule

// File: tb/tb_histogram_accumulator.sv
// Scoreboard bench: 16-bit and 4-bit counter instances share stimulus,
// expected read data is queued at issue and checked on rd_valid.
module tb_histogram_accumulator;
    import hist_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] Addr = '0;
    logic       Memory_add = 1'b0;
    logic       rd_req = 1'b0;
    logic [7:0] rd_addr = '0;
    logic       clear_req = 1'b0;

    logic        rd_ready16, rd_valid16, busy16, sat16, drop16;
    logic [15:0] rd_data16;
    logic        rd_ready4, rd_valid4, busy4, sat4, drop4;
    logic [3:0]  rd_data4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp16[$];
    int exp4[$];
    int acc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    histogram_accumulator u16 (
        .clk(clk), .rst_n(rst_n), .Addr(Addr), .Memory_add(Memory_add),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready16),
        .rd_valid(rd_valid16), .rd_data(rd_data16), .clear_req(clear_req),
        .busy(busy16), .saturated(sat16), .dropped(drop16)
    );

    histogram_accumulator #(.ADDR_W(8), .COUNT_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .Addr(Addr), .Memory_add(Memory_add),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready4),
        .rd_valid(rd_valid4), .rd_data(rd_data4), .clear_req(clear_req),
        .busy(busy4), .saturated(sat4), .dropped(drop4)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever a read result appears
    always @(negedge clk) begin
        if (rd_valid16) begin
            if (exp16.size() == 0) begin
                check("unexpected rd_valid16", 1, 0);
            end else begin
                check("rd_data16", int'(rd_data16), exp16.pop_front());
                check("rd_latency", cyc - acc_q.pop_front(), 2);
            end
        end
        if (rd_valid4) begin
            if (exp4.size() == 0) begin
                check("unexpected rd_valid4", 1, 0);
            end else begin
                check("rd_data4", int'(rd_data4), exp4.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy16 && n < 400) begin
            tick();
            n++;
        end
        if (busy16) check("sweep timeout", 1, 0);
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!rd_ready16 && w < 50) begin
            tick();
            w++;
        end
        check("rd_ready before issue", int'(rd_ready16), 1);
    endtask

    task automatic host_read(input int a, input int e16, input int e4);
        wait_ready();
        exp16.push_back(e16);
        exp4.push_back(e4);
        acc_q.push_back(cyc);
        rd_addr = 8'(a);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        ticks(3);
    endtask

    task automatic incr(input int a, input int hi, input int lo);
        Addr = 8'(a);
        Memory_add = 1'b1;
        ticks(hi);
        Memory_add = 1'b0;
        ticks(lo);
    endtask

    initial begin
        int n;
        ticks(3);
        check("reset rd_ready", int'(rd_ready16), 0);
        check("reset rd_valid", int'(rd_valid16), 0);
        check("reset rd_data", int'(rd_data16), 0);
        check("reset busy", int'(busy16), 1);
        check("reset saturated", int'(sat16), 0);
        check("reset dropped", int'(drop16), 0);
        check("reset busy4", int'(busy4), 1);

        rst_n = 1'b1;
        ticks(10);
        check("sweep rd_ready", int'(rd_ready16), 0);
        check("sweep busy", int'(busy16), 1);
        wait_idle(n);
        check("sweep length", n, 246);

        host_read(BIN_ZERO, 0, 0);

        repeat (3) incr(130, 6, 2);
        host_read(130, 3, 3);
        host_read(129, 0, 0);
        check("no drop normal", int'(drop16), 0);

        // Host read and increment edge for the same bin in one cycle
        wait_ready();
        exp16.push_back(3);
        exp4.push_back(3);
        acc_q.push_back(cyc);
        Addr = 8'd130;
        rd_addr = 8'd130;
        Memory_add = 1'b1;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        Memory_add = 1'b0;
        ticks(6);
        host_read(130, 4, 4);

        repeat (20) incr(5, 2, 4);
        host_read(5, 20, 15);
        check("saturated16", int'(sat16), 0);
        check("saturated4", int'(sat4), 1);
        check("no drop sat", int'(drop16), 0);

        // Edges 2 cycles apart while an RMW is in flight
        wait_ready();
        repeat (3) incr(7, 1, 1);
        ticks(6);
        host_read(7, 2, 2);
        check("dropped16", int'(drop16), 1);
        check("dropped4", int'(drop4), 1);

        // Clear issued while an increment to bin 9 is mid-RMW
        wait_ready();
        Addr = 8'd9;
        Memory_add = 1'b1;
        ticks(2);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        Memory_add = 1'b0;
        check("clear busy", int'(busy16), 1);
        check("clear sat4", int'(sat4), 0);
        check("clear drop", int'(drop16), 0);
        check("clear rd_ready", int'(rd_ready16), 0);
        incr(5, 1, 1);
        rd_addr = 8'd5;
        rd_req = 1'b1;
        ticks(20);
        rd_req = 1'b0;
        check("clear ignores edge", int'(drop16), 0);
        wait_idle(n);
        host_read(5, 0, 0);
        host_read(7, 0, 0);
        host_read(9, 0, 0);
        host_read(130, 0, 0);

        // Reset in the middle of a sweep
        repeat (2) incr(130, 2, 4);
        host_read(130, 2, 2);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        ticks(100);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", int'(busy16), 1);
        check("mid reset rd_data", int'(rd_data16), 0);
        check("mid reset rd_ready", int'(rd_ready16), 0);
        ticks(2);
        rst_n = 1'b1;
        wait_idle(n);
        check("resweep length", n, 256);
        host_read(130, 0, 0);
        host_read(255, 0, 0);

        ticks(5);
        check("scoreboard drained", exp16.size() + exp4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
